// File: rtl/mac_pkg.sv
// Shared types and saturation helpers for the vector MAC.
// Values travel as 64-bit signed so one function body serves any WIDTH up to 32.
package mac_pkg;

  typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;

  function automatic logic signed [63:0] max_of(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] min_of(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] prod, input int width);
    if (prod > max_of(width)) return max_of(width);
    else if (prod < min_of(width)) return min_of(width);
    else return prod;
  endfunction

  function automatic logic clamp_hit(input logic signed [63:0] prod, input int width);
    return (prod > max_of(width)) || (prod < min_of(width));
  endfunction

  // The exact 64-bit sum leaves range exactly when the same-sign overflow rule fires.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] x, input logic signed [63:0] y,
                                                 input int width);
    return sat_clamp(x + y, width);
  endfunction

  function automatic logic add_hit(input logic signed [63:0] x, input logic signed [63:0] y,
                                   input int width);
    return clamp_hit(x + y, width);
  endfunction

endpackage

// File: rtl/mac_sat_mult_pipe.sv
// Pipelined signed multiplier with valid/last tags, clamp to WIDTH and a product register.
// Emits a one-cycle sat pulse alongside a clamped valid product.
module mac_sat_mult_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH       = 14,
  parameter int MULT_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    prod_valid,
  output logic                    prod_last,
  output logic signed [WIDTH-1:0] prod,
  output logic                    prod_sat
);

  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0] p_d [MULT_STAGES];
  logic signed [PW-1:0] p_q [MULT_STAGES];
  logic                 v_d [MULT_STAGES];
  logic                 v_q [MULT_STAGES];
  logic                 l_d [MULT_STAGES];
  logic                 l_q [MULT_STAGES];

  logic                    pv_d, pv_q;
  logic                    pl_d, pl_q;
  logic                    psat_d, psat_q;
  logic signed [WIDTH-1:0] prod_d, prod_q;

  assign p_d[0] = PW'(a) * PW'(b);
  assign v_d[0] = in_valid;
  assign l_d[0] = in_last;

  genvar gi;
  for (gi = 1; gi < MULT_STAGES; gi++) begin : g_stage
    assign p_d[gi] = p_q[gi-1];
    assign v_d[gi] = v_q[gi-1];
    assign l_d[gi] = l_q[gi-1];
  end

  always_comb begin
    pv_d   = v_q[MULT_STAGES-1];
    pl_d   = v_q[MULT_STAGES-1] && l_q[MULT_STAGES-1];
    prod_d = WIDTH'(sat_clamp(64'(p_q[MULT_STAGES-1]), WIDTH));
    psat_d = v_q[MULT_STAGES-1] && clamp_hit(64'(p_q[MULT_STAGES-1]), WIDTH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MULT_STAGES; i++) begin
        p_q[i] <= '0;
        v_q[i] <= 1'b0;
        l_q[i] <= 1'b0;
      end
      pv_q   <= 1'b0;
      pl_q   <= 1'b0;
      psat_q <= 1'b0;
      prod_q <= '0;
    end else begin
      for (int i = 0; i < MULT_STAGES; i++) begin
        p_q[i] <= p_d[i];
        v_q[i] <= v_d[i];
        l_q[i] <= l_d[i];
      end
      pv_q   <= pv_d;
      pl_q   <= pl_d;
      psat_q <= psat_d;
      prod_q <= prod_d;
    end
  end

  assign prod_valid = pv_q;
  assign prod_last  = pl_q;
  assign prod       = prod_q;
  assign prod_sat   = psat_q;

endmodule

// File: rtl/mac_vec_sat_pipe.sv
// Saturating signed dot product over vectors of programmable length with valid/ready on both sides.
// Holds the ACC/DRAIN/OUT control, term counter, accumulator and output register.
module mac_vec_sat_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH       = 14,
  parameter int MULT_STAGES = 2,
  parameter int LEN_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic [LEN_W-1:0]        len,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] f,
  output logic                    out_sat
);

  state_t                  state_d, state_q;
  logic                    in_ready_d, in_ready_q;
  logic                    out_valid_d, out_valid_q;
  logic [LEN_W-1:0]        cnt_d, cnt_q;
  logic [LEN_W-1:0]        len_d, len_q;
  logic signed [WIDTH-1:0] acc_d, acc_q;
  logic                    sat_d, sat_q;
  logic signed [WIDTH-1:0] f_d, f_q;
  logic                    out_sat_d, out_sat_q;

  logic                    accept, last_beat;
  logic [LEN_W-1:0]        len_cur, len_m1;
  logic                    prod_valid, prod_last, prod_sat;
  logic signed [WIDTH-1:0] prod;
  logic signed [WIDTH-1:0] sum_val;
  logic                    sum_hit;

  mac_sat_mult_pipe #(
    .WIDTH       (WIDTH),
    .MULT_STAGES (MULT_STAGES)
  ) u_mult (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (accept),
    .in_last    (last_beat),
    .a          (a),
    .b          (b),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod       (prod),
    .prod_sat   (prod_sat)
  );

  assign accept = in_valid && in_ready_q;

  // The first beat of a vector uses len straight from the port; a zero length behaves as one.
  always_comb begin
    len_cur   = (cnt_q == '0) ? len : len_q;
    len_m1    = (len_cur == '0) ? '0 : len_cur - LEN_W'(1);
    last_beat = accept && (cnt_q == len_m1);
    sum_val   = WIDTH'(sat_add(64'(acc_q), 64'(prod), WIDTH));
    sum_hit   = add_hit(64'(acc_q), 64'(prod), WIDTH);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    f_d       = f_q;
    out_sat_d = out_sat_q;

    if (prod_valid) begin
      acc_d = sum_val;
      sat_d = sat_q || sum_hit || prod_sat;
    end

    case (state_q)
      ACC: begin
        if (accept) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == '0) len_d = len;
          if (last_beat) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The final sum goes straight to f so the result shows without an extra cycle.
        if (prod_valid && prod_last) begin
          f_d       = sum_val;
          out_sat_d = sat_q || sum_hit || prod_sat;
          acc_d     = '0;
          sat_d     = 1'b0;
          cnt_d     = '0;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (out_valid_q && out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase

    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ACC;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      f_q         <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      f_q         <= f_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_vec_sat_pipe.sv
// Scoreboard bench for mac_vec_sat_pipe: directed corner vectors plus randomized vectors
// checked against a plain-arithmetic dot-product model.
module tb_mac_vec_sat_pipe;

  localparam int WIDTH       = 14;
  localparam int MULT_STAGES = 2;
  localparam int LEN_W       = 8;
  localparam int MAXV        = (1 << (WIDTH - 1)) - 1;
  localparam int MINV        = -(1 << (WIDTH - 1));

  logic                    clk       = 1'b0;
  logic                    reset     = 1'b1;
  logic                    in_valid  = 1'b0;
  logic                    out_ready = 1'b1;
  logic                    in_ready, out_valid, out_sat;
  logic signed [WIDTH-1:0] a = '0, b = '0, f;
  logic [LEN_W-1:0]        len = '0;

  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  bit   rand_bp = 1'b0;
  logic ov_prev = 1'b0;

  int exp_f_q[$];
  int exp_s_q[$];
  int lat_q[$];
  int va[16];
  int vb[16];

  mac_vec_sat_pipe #(
    .WIDTH       (WIDTH),
    .MULT_STAGES (MULT_STAGES),
    .LEN_W       (LEN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .len       (len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Dot product by the rules: clamp each product, then clamp each running sum.
  task automatic ref_dot(input int n, output int fv, output int sv);
    int acc;
    int p;
    acc = 0;
    sv  = 0;
    for (int i = 0; i < n; i++) begin
      p = va[i] * vb[i];
      if (p > MAXV) begin p = MAXV; sv = 1; end
      else if (p < MINV) begin p = MINV; sv = 1; end
      acc = acc + p;
      if (acc > MAXV) begin acc = MAXV; sv = 1; end
      else if (acc < MINV) begin acc = MINV; sv = 1; end
    end
    fv = acc;
  endtask

  // Monitor: latency on each rising out_valid, result on each output handshake.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && !ov_prev) begin
        if (lat_q.size() == 0) check("spurious_out_valid", 1, 0);
        else begin
          int l;
          l = lat_q.pop_front();
          check("latency", cyc - l + 1, MULT_STAGES + 2);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_f_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          int ef;
          int es;
          ef = exp_f_q.pop_front();
          es = exp_s_q.pop_front();
          $display("txn: f=%0d sat=%0d (expected f=%0d sat=%0d) at cycle %0d", f, out_sat, ef, es, cyc);
          check("result_f", int'(f), ef);
          check("result_sat", int'(out_sat), es);
        end
      end
    end
    ov_prev <= out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = ($urandom_range(3, 0) != 0);
  endtask

  task automatic beat(input int av, input int bv, input int ln, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    a        = WIDTH'(av);
    b        = WIDTH'(bv);
    len      = LEN_W'(ln);
    for (int k = 0; k < 200; k++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    if (!ok) check("in_ready_timeout", 0, 1);
  endtask

  task automatic run_vector(input int lenf, input int max_gap, input bit directed,
                            input int ef, input int es);
    int n;
    int mf;
    int ms;
    bit ok;
    n = (lenf == 0) ? 1 : lenf;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(max_gap, 0)) tick();
      beat(va[i], vb[i], (i == 0) ? lenf : int'($urandom_range(255, 0)), ok);
    end
    lat_q.push_back(cyc);
    ref_dot(n, mf, ms);
    exp_f_q.push_back(directed ? ef : mf);
    exp_s_q.push_back(directed ? es : ms);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400; k++) begin
      if (exp_f_q.size() == 0) return;
      tick();
    end
    check("drain_timeout", exp_f_q.size(), 0);
  endtask

  function automatic int rand_operand();
    case ($urandom_range(2, 0))
      0: return int'($urandom_range(100, 0)) - 50;
      1: return int'($urandom_range(MAXV - MINV, 0)) + MINV;
      default: begin
        case ($urandom_range(3, 0))
          0: return MAXV;
          1: return MINV;
          2: return -1;
          default: return 1;
        endcase
      end
    endcase
  endfunction

  initial begin
    bit ok;
    int lenf;
    int n;

    reset = 1'b0;
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_f", int'(f), 0);
    check("reset_out_sat", int'(out_sat), 0);
    check("reset_in_ready", int'(in_ready), 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 check("in_ready_before_first_clk", int'(in_ready), 0);
    tick();
    check("in_ready_after_release", int'(in_ready), 1);

    // Basic back-to-back vector.
    va[0] = 2;  vb[0] = 3;
    va[1] = 4;  vb[1] = 5;
    va[2] = -1; vb[2] = 6;
    run_vector(3, 0, 1'b1, 20, 0);
    wait_drain();
    check("in_ready_after_out", int'(in_ready), 1);

    // Product clamps.
    va[0] = 200;  vb[0] = 100;
    run_vector(1, 0, 1'b1, MAXV, 1);
    va[0] = MINV; vb[0] = MINV;
    run_vector(1, 0, 1'b1, MAXV, 1);

    // Accumulator saturation and sticky clear.
    va[0] = MAXV; vb[0] = 1;
    va[1] = 100;  vb[1] = 1;
    run_vector(2, 0, 1'b1, MAXV, 1);
    va[0] = MINV; vb[0] = 1;
    va[1] = -1;   vb[1] = 1;
    run_vector(2, 0, 1'b1, MINV, 1);
    va[0] = 1; vb[0] = 1;
    run_vector(1, 0, 1'b1, 1, 0);

    // Gapped vector followed by the same vector contiguous.
    va[0] = 100; vb[0] = -7;
    va[1] = 55;  vb[1] = 3;
    va[2] = -30; vb[2] = -30;
    va[3] = 12;  vb[3] = 12;
    run_vector(4, 3, 1'b1, 509, 0);
    run_vector(4, 0, 1'b1, 509, 0);
    wait_drain();

    // Backpressure while holding a result.
    out_ready = 1'b0;
    va[0] = 7; vb[0] = 8;
    run_vector(1, 0, 1'b1, 56, 0);
    for (int k = 0; k < 50; k++) begin
      if (out_valid) break;
      tick();
    end
    check("bp_out_valid_rise", int'(out_valid), 1);
    repeat (5) begin
      in_valid = 1'b1;
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      len = LEN_W'($urandom);
      tick();
      check("bp_out_valid_held", int'(out_valid), 1);
      check("bp_f_held", int'(f), 56);
      check("bp_sat_held", int'(out_sat), 0);
      check("bp_in_ready_low", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check("bp_in_ready_after", int'(in_ready), 1);

    // Asynchronous reset mid-vector.
    beat(5, 5, 3, ok);
    beat(6, 6, 0, ok);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_f", int'(f), 0);
    check("abort_out_sat", int'(out_sat), 0);
    check("abort_in_ready", int'(in_ready), 0);
    repeat (4) @(posedge clk);
    #1 check("abort_out_valid_held", int'(out_valid), 0);
    #3 reset = 1'b1;
    tick();
    check("abort_in_ready_release", int'(in_ready), 1);
    va[0] = 3; vb[0] = 3;
    run_vector(1, 0, 1'b1, 9, 0);
    va[0] = 5; vb[0] = 5;
    run_vector(0, 0, 1'b1, 25, 0);
    wait_drain();

    // Randomized vectors with random output stalls.
    rand_bp = 1'b1;
    for (int v = 0; v < 30; v++) begin
      lenf = $urandom_range(6, 0);
      n    = (lenf == 0) ? 1 : lenf;
      for (int i = 0; i < n; i++) begin
        va[i] = rand_operand();
        vb[i] = rand_operand();
      end
      run_vector(lenf, 2, 1'b0, 0, 0);
    end
    wait_drain();
    rand_bp   = 1'b0;
    out_ready = 1'b1;
    tick();
    check("final_lat_queue_empty", lat_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_vec_sat_pipe.md
Name: mac_vec_sat_pipe

Overview:
- Parametrised successor to the fixed 14-bit MAC: a signed, saturating multiply-accumulate over vectors of programmable length.
- Uses valid/ready handshakes on input and output, replacing externally sequenced enables.
- Accepts one (a,b) term per handshake, counts terms, and presents the saturated dot product once per vector with a saturation flag.
- Sits between the layer controller/memories and the activation stage of each generated FCNN neuron.

Parameters:
- WIDTH, 14: signed operand, product-clamp and accumulator width.
- MULT_STAGES, 2: pipeline stages inside the multiplier (≥1).
- LEN_W, 8: width of the vector-length port.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  term (a,b) valid.
- in_ready  out  1  block accepts a term this cycle.
- a  in  WIDTH  signed operand.
- b  in  WIDTH  signed operand.
- len  in  LEN_W  terms per vector; sampled on the first accepted beat of each vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- f  out  WIDTH  signed saturated dot product.
- out_sat  out  1  a product or sum clamp occurred in this vector.

Behaviour:
- Reset (reset=0, async):
  - state=ACC; pipeline valids, accumulator, term counter, f and out_sat all 0; out_valid=0.
  - in_ready=1 from the first clock after release.
- Accept: a beat is accepted when in_valid && in_ready.
  - First beat of a vector latches len. len=0 is treated as 1.
- Datapath, all stages advance every cycle with no internal stall:
  - Multiplier: full 2*WIDTH signed product through MULT_STAGES registers, valid bit shifted alongside.
  - Clamp: product clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1], then registered in the product register.
  - Accumulate: acc <= sat_add(acc, prod_reg) on the cycle the product register is valid.
    - Overflow: both operands positive with a negative result → MAX; both negative with a non-negative result → MIN.
  - Clamp events at either stage set a sticky per-vector sat bit.
- States:
  - ACC: in_ready=1. Term counter increments per accepted beat. On accepting the last beat (count==len-1) → DRAIN, and in_ready drops in the following cycle.
  - DRAIN: in_ready=0. Wait until the last term's product has been added. Then f<=acc, out_sat<=sat, acc<=0, sat<=0, counter<=0, → OUT.
  - OUT: out_valid=1. f and out_sat held stable while out_ready=0. On out_valid && out_ready → ACC, with out_valid=0 and in_ready=1 from the next cycle.
- Latency: last term accepted at cycle t gives out_valid high at t+MULT_STAGES+2.
- Gaps: in_valid gaps inside a vector do not affect the result. Idle pipeline slots carry valid=0 and do not touch the accumulator.
- Masking: in_valid during DRAIN/OUT is ignored, and a/b are don't-care when no beat is accepted.
- Reset mid-vector or mid-OUT aborts everything; no partial result is emitted.
- Boundary values:
  - Products -2^(WIDTH-1)*-2^(WIDTH-1) clamp to MAX.
  - MIN+MIN saturates to MIN and MAX+1 saturates to MAX, both setting out_sat.

Decomposition:
- Shared package mac_pkg:
  - state enum {ACC, DRAIN, OUT}.
  - Functions sat_clamp(prod, width) and sat_add(x, y, width), both pure combinational.
  - MAX/MIN constants derived from WIDTH.
- Sub-module mac_sat_mult_pipe (parameters WIDTH, MULT_STAGES):
  - Pipelined signed multiply with valid shift register, output clamp and product register, plus a sat pulse output.
  - Top level holds the FSM, counter, accumulator and output register.

Test Plan (WIDTH=14, MULT_STAGES=2, LEN_W=8):
- len=3, beats (2,3),(4,5),(-1,6) back-to-back, out_ready=1 → f=20, out_sat=0, out_valid exactly 4 cycles after third accept, then in_ready=1.
- len=1, (200,100) → product 20000 clamps, f=8191, out_sat=1. Then len=1, (-8192,-8192) → f=8191, out_sat=1.
- Accumulator saturation:
  - len=2, (8191,1),(100,1) → f=8191, out_sat=1.
  - len=2, (-8192,1),(-1,1) → f=-8192, out_sat=1.
  - Next vector len=1, (1,1) → f=1, out_sat=0 (sticky cleared).
- len=4 with 0–3 idle cycles between beats → f equals contiguous result. Two consecutive vectors: second result is independent of the first (acc cleared).
- Backpressure: out_ready=0 for 5 cycles in OUT → out_valid, f, out_sat stable, in_ready=0, in_valid beats ignored. out_ready=1 → handshake completes, in_ready=1 the next cycle.
- Reset low asynchronously after 2 of 3 beats → out_valid=0, f=0 immediately. After release, vector len=1, (3,3) → f=9; len=0 with (5,5) → treated as length 1, f=25.
